// File: rtl/minesweeper_board_core.sv
// -----------------------------------------------------------------------------
// minesweeper_board_core
//
// Game-state core of the minesweeper: a mine map plus a per-cell cover map,
// addressed by the cursor. It generates mines from a 32-bit LFSR, returns the
// true, cover and player-visible values of the cursor cell combinationally,
// and latches game-over when a mine is opened.
//
// Ports:
//   board_clk          system clock, all state changes on the rising edge
//   glob_reset         asynchronous active-high reset of all state
//   reset              synchronous new-game clear (seed/LFSR keep running)
//   init_pulse         start mine generation (ignored while generating)
//   open, flag         open / toggle-flag the cursor cell (open wins)
//   x_coord, y_coord   cursor column / row
//   cell_val_board     true value: 5'h1F mine, else neighbour mine count
//   cell_val_cover     00 covered, 01 opened, 10 flagged
//   cell_val_apparent  player-visible value (5'h10 covered, 5'h11 flagged)
//   num_mines          mines placed during generation
//   seed               free-running seed counter
//   rand_val           LFSR state ("rand" is a reserved word in SystemVerilog)
//   is_init            0 empty, 1 generating, 2 ready
//   init_x, init_y     generation cell index
//   game_over          sticky mine-opened flag
//
// Build option: define NUM_MINES_EN to build the mine counter; otherwise
// num_mines is tied to zero.
// -----------------------------------------------------------------------------
module minesweeper_board_core #(
    parameter int X_SIZE      = 16,
    parameter int Y_SIZE      = 16,
    parameter int X_BITS      = 4,
    parameter int Y_BITS      = 4,
    parameter int MINE_THRESH = 40
) (
    input  logic                     board_clk,
    input  logic                     glob_reset,
    input  logic                     reset,
    input  logic                     init_pulse,
    input  logic                     open,
    input  logic                     flag,
    input  logic [X_BITS-1:0]        x_coord,
    input  logic [Y_BITS-1:0]        y_coord,
    output logic [4:0]               cell_val_board,
    output logic [1:0]               cell_val_cover,
    output logic [4:0]               cell_val_apparent,
    output logic [X_BITS+Y_BITS-1:0] num_mines,
    output logic [31:0]              seed,
    output logic [31:0]              rand_val,
    output logic [1:0]               is_init,
    output logic [X_BITS-1:0]        init_x,
    output logic [Y_BITS-1:0]        init_y,
    output logic                     game_over
);

    localparam int IDX_W  = X_BITS + Y_BITS;
    localparam int N_CELL = X_SIZE * Y_SIZE;
    localparam int CELL_W = (N_CELL > 1) ? $clog2(N_CELL) : 1;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_GEN   = 2'd1,
        ST_READY = 2'd2
    } state_t;

    // One Galois LFSR step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // Mine bit at a signed coordinate; off-board neighbours read as no mine.
    function automatic logic mine_at(input logic [N_CELL-1:0] map, input int x, input int y);
        logic [CELL_W-1:0] idx;
        logic              res;
        idx = CELL_W'(0);
        res = 1'b0;
        if (x >= 0 && x < X_SIZE && y >= 0 && y < Y_SIZE) begin
            idx = CELL_W'(y * X_SIZE + x);
            res = map[idx];
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

    state_t               state_r, state_next_s;
    logic [31:0]          seed_r, rand_r;
    logic [IDX_W-1:0]     gen_idx_r;
    logic [N_CELL-1:0]    mine_r;
    logic [N_CELL-1:0]    opened_r;
    logic [N_CELL-1:0]    flagged_r;
    logic                 game_over_r;

    logic                 init_acc_s;
    logic                 clear_s;
    logic                 play_ok_s;
    logic                 gen_last_s;
    logic                 gen_ok_s;
    logic                 gen_mine_s;
    logic [CELL_W-1:0]    gen_cell_s;
    logic                 cur_ok_s;
    logic [CELL_W-1:0]    cur_cell_s;
    logic [3:0]           nbr_cnt_s;
    logic [4:0]           board_s;
    logic [1:0]           cover_s;
    logic [4:0]           apparent_s;
    logic [X_BITS-1:0]    gen_x_s;
    logic [Y_BITS-1:0]    gen_y_s;

    assign gen_x_s    = gen_idx_r[X_BITS-1:0];
    assign gen_y_s    = gen_idx_r[IDX_W-1:X_BITS];
    assign gen_last_s = (gen_idx_r == {IDX_W{1'b1}});
    assign gen_ok_s   = (int'(gen_x_s) < X_SIZE) && (int'(gen_y_s) < Y_SIZE);
    assign gen_cell_s = CELL_W'(int'(gen_y_s) * X_SIZE + int'(gen_x_s));
    assign gen_mine_s = (rand_r[7:0] < 8'(MINE_THRESH));

    assign cur_ok_s   = (int'(x_coord) < X_SIZE) && (int'(y_coord) < Y_SIZE);
    assign cur_cell_s = CELL_W'(int'(y_coord) * X_SIZE + int'(x_coord));

    // A new game (reset) overrides everything; init is refused mid-generation.
    assign init_acc_s = init_pulse && !reset && (state_r != ST_GEN);
    assign clear_s    = reset || init_acc_s;
    assign play_ok_s  = !clear_s && (state_r == ST_READY) && !game_over_r && cur_ok_s;

    // Game-phase state register.
    always_ff @(posedge board_clk or posedge glob_reset) begin
        if (glob_reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: reset > init > end of generation.
    always_comb begin
        state_next_s = state_r;
        if (reset) begin
            state_next_s = ST_EMPTY;
        end else if (init_acc_s) begin
            state_next_s = ST_GEN;
        end else begin
            case (state_r)
                ST_EMPTY: state_next_s = ST_EMPTY;
                ST_GEN:   state_next_s = gen_last_s ? ST_READY : ST_GEN;
                ST_READY: state_next_s = ST_READY;
                default:  state_next_s = ST_EMPTY;
            endcase
        end
    end

    // Free-running seed counter and LFSR; LFSR is reloaded from the seed on init.
    always_ff @(posedge board_clk or posedge glob_reset) begin
        if (glob_reset) begin
            seed_r <= 32'd0;
            rand_r <= 32'd1;
        end else begin
            seed_r <= seed_r + 32'd1;
            if (init_acc_s) begin
                rand_r <= (seed_r == 32'd0) ? 32'd1 : seed_r;
            end else begin
                rand_r <= lfsr_step(rand_r);
            end
        end
    end

    // Generation index and mine map: one cell per cycle while generating.
    always_ff @(posedge board_clk or posedge glob_reset) begin
        if (glob_reset) begin
            gen_idx_r <= {IDX_W{1'b0}};
            mine_r    <= {N_CELL{1'b0}};
        end else if (clear_s) begin
            gen_idx_r <= {IDX_W{1'b0}};
            mine_r    <= {N_CELL{1'b0}};
        end else if (state_r == ST_GEN) begin
            gen_idx_r <= gen_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            if (gen_ok_s) begin
                mine_r[gen_cell_s] <= gen_mine_s;
            end
        end
    end

`ifdef NUM_MINES_EN
    logic [IDX_W-1:0] num_mines_r;

    // Count of mines placed during the current generation.
    always_ff @(posedge board_clk or posedge glob_reset) begin
        if (glob_reset) begin
            num_mines_r <= {IDX_W{1'b0}};
        end else if (clear_s) begin
            num_mines_r <= {IDX_W{1'b0}};
        end else if (state_r == ST_GEN && gen_ok_s && gen_mine_s) begin
            num_mines_r <= num_mines_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end
    end
`endif

    // Cover map: opened and flagged are mutually exclusive bits per cell.
    always_ff @(posedge board_clk or posedge glob_reset) begin
        if (glob_reset) begin
            opened_r  <= {N_CELL{1'b0}};
            flagged_r <= {N_CELL{1'b0}};
        end else if (clear_s) begin
            opened_r  <= {N_CELL{1'b0}};
            flagged_r <= {N_CELL{1'b0}};
        end else if (play_ok_s) begin
            if (open) begin
                if (!opened_r[cur_cell_s] && !flagged_r[cur_cell_s]) begin
                    opened_r[cur_cell_s] <= 1'b1;
                end
            end else if (flag) begin
                if (!opened_r[cur_cell_s]) begin
                    flagged_r[cur_cell_s] <= !flagged_r[cur_cell_s];
                end
            end
        end
    end

    // Sticky game-over: set once an opened mine is visible under the cursor.
    always_ff @(posedge board_clk or posedge glob_reset) begin
        if (glob_reset) begin
            game_over_r <= 1'b0;
        end else if (clear_s) begin
            game_over_r <= 1'b0;
        end else if (apparent_s == 5'b11111) begin
            game_over_r <= 1'b1;
        end
    end

    // Neighbour mine count around the cursor cell.
    always_comb begin
        nbr_cnt_s = 4'd0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nbr_cnt_s = nbr_cnt_s + {3'b000,
                    ((dx != 0) || (dy != 0)) ?
                        mine_at(mine_r, int'(x_coord) + dx, int'(y_coord) + dy) : 1'b0};
            end
        end
    end

    // Cursor cell true value, cover state and visible value.
    always_comb begin
        board_s    = 5'd0;
        cover_s    = 2'b00;
        apparent_s = 5'b10000;
        if (cur_ok_s) begin
            board_s = mine_r[cur_cell_s] ? 5'b11111 : {1'b0, nbr_cnt_s};
            cover_s = {flagged_r[cur_cell_s], opened_r[cur_cell_s]};
        end else begin
            board_s = 5'd0;
            cover_s = 2'b00;
        end
        case (cover_s)
            2'b00:   apparent_s = 5'b10000;
            2'b01:   apparent_s = board_s;
            default: apparent_s = 5'b10001;
        endcase
    end

    // Output drive.
    always_comb begin
        is_init           = state_r;
        seed              = seed_r;
        rand_val          = rand_r;
        init_x            = gen_x_s;
        init_y            = gen_y_s;
        game_over         = game_over_r;
        cell_val_board    = board_s;
        cell_val_cover    = cover_s;
        cell_val_apparent = apparent_s;
`ifdef NUM_MINES_EN
        num_mines         = num_mines_r;
`else
        num_mines         = {IDX_W{1'b0}};
`endif
    end

endmodule

// File: tb/tb_minesweeper_board_core.sv
module tb_minesweeper_board_core;

    logic        board_clk  = 1'b0;
    logic        glob_reset = 1'b0;
    logic        reset      = 1'b0;
    logic        init_pulse = 1'b0;
    logic        open       = 1'b0;
    logic        flag       = 1'b0;
    logic [3:0]  x_coord    = 4'd0;
    logic [3:0]  y_coord    = 4'd0;
    logic [4:0]  cell_val_board;
    logic [1:0]  cell_val_cover;
    logic [4:0]  cell_val_apparent;
    logic [7:0]  num_mines;
    logic [31:0] seed;
    logic [31:0] rand_val;
    logic [1:0]  is_init;
    logic [3:0]  init_x;
    logic [3:0]  init_y;
    logic        game_over;

    minesweeper_board_core dut (
        .board_clk        (board_clk),
        .glob_reset       (glob_reset),
        .reset            (reset),
        .init_pulse       (init_pulse),
        .open             (open),
        .flag             (flag),
        .x_coord          (x_coord),
        .y_coord          (y_coord),
        .cell_val_board   (cell_val_board),
        .cell_val_cover   (cell_val_cover),
        .cell_val_apparent(cell_val_apparent),
        .num_mines        (num_mines),
        .seed             (seed),
        .rand_val         (rand_val),
        .is_init          (is_init),
        .init_x           (init_x),
        .init_y           (init_y),
        .game_over        (game_over)
    );

    always #5 board_clk = ~board_clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [31:0] seed_m;
    bit          mine_m [16][16];
    logic [1:0]  cov_m  [16][16];
    int          mines_m;
    bit          ready_m;
    bit          go_m;

    always @(posedge board_clk or posedge glob_reset) begin
        if (glob_reset) seed_m <= 32'd0;
        else            seed_m <= seed_m + 32'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic [31:0] half;
        half = v / 32'd2;
        return (v % 32'd2 == 32'd1) ? (half ^ 32'h80200003) : half;
    endfunction

    task automatic clear_model();
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) begin
                mine_m[x][y] = 1'b0;
                cov_m[x][y]  = 2'b00;
            end
        mines_m = 0;
    endtask

    task automatic build_model(input logic [31:0] start);
        logic [31:0] r;
        r = start;
        mines_m = 0;
        for (int i = 0; i < 256; i++) begin
            mine_m[i % 16][i / 16] = ((r % 32'd256) < 32'd40);
            if (mine_m[i % 16][i / 16]) mines_m++;
            cov_m[i % 16][i / 16] = 2'b00;
            r = lfsr_next(r);
        end
    endtask

    function automatic int exp_board(input int x, input int y);
        int c;
        c = 0;
        if (mine_m[x][y]) return 31;
        for (int dx = -1; dx <= 1; dx++)
            for (int dy = -1; dy <= 1; dy++)
                if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 16 &&
                    y + dy >= 0 && y + dy < 16 && mine_m[x + dx][y + dy])
                    c++;
        return c;
    endfunction

    function automatic int exp_app(input int x, input int y);
        if (cov_m[x][y] == 2'b00) return 16;
        if (cov_m[x][y] == 2'b01) return exp_board(x, y);
        return 17;
    endfunction

    task automatic look(input int x, input int y);
        x_coord = 4'(x);
        y_coord = 4'(y);
        #1;
    endtask

    task automatic check_cell(input int x, input int y);
        look(x, y);
        check_eq("board", 32'(cell_val_board), 32'(exp_board(x, y)));
        check_eq("cover", 32'(cell_val_cover), 32'(cov_m[x][y]));
        check_eq("apparent", 32'(cell_val_apparent), 32'(exp_app(x, y)));
    endtask

    task automatic cyc(input bit i, input bit o, input bit f, input bit r);
        init_pulse = i; open = o; flag = f; reset = r;
        @(posedge board_clk);
        #1;
        init_pulse = 1'b0; open = 1'b0; flag = 1'b0; reset = 1'b0;
    endtask

    task automatic do_op(input int x, input int y, input bit o, input bit f);
        look(x, y);
        cyc(1'b0, o, f, 1'b0);
        if (ready_m && !go_m) begin
            if (o) begin
                if (cov_m[x][y] == 2'b00) cov_m[x][y] = 2'b01;
            end else if (f) begin
                if (cov_m[x][y] == 2'b00)      cov_m[x][y] = 2'b10;
                else if (cov_m[x][y] == 2'b10) cov_m[x][y] = 2'b00;
            end
        end
        check_cell(x, y);
        check_eq("game_over_op", 32'(game_over), 32'(go_m));
    endtask

    task automatic find_cell(input bit want_mine, output int fx, output int fy, output bit ok);
        int base;
        base = int'($urandom_range(0, 255));
        ok = 1'b0; fx = 0; fy = 0;
        for (int k = 0; k < 256; k++) begin
            int c;
            c = (base + k) % 256;
            if (!ok && mine_m[c % 16][c / 16] == want_mine && cov_m[c % 16][c / 16] == 2'b00) begin
                ok = 1'b1; fx = c % 16; fy = c / 16;
            end
        end
    endtask

    task automatic run_gen(input int inj);
        int n;
        n = 0;
        while (is_init == 2'd1 && n < 400) begin
            if (n == 100) check_eq("gen_index", 32'({init_y, init_x}), 32'd100);
            if (n == inj) init_pulse = 1'b1;
            @(posedge board_clk);
            #1;
            init_pulse = 1'b0;
            n++;
        end
        check_eq("gen_length", 32'(n), 32'd256);
        check_eq("ready_state", 32'(is_init), 32'd2);
        check_eq("index_wrap", 32'({init_y, init_x}), 32'd0);
`ifdef NUM_MINES_EN
        check_eq("num_mines", 32'(num_mines), 32'(mines_m % 256));
`else
        check_eq("num_mines", 32'(num_mines), 32'd0);
`endif
        ready_m = 1'b1;
    endtask

    task automatic start_init(input int inj);
        logic [31:0] s;
        s = seed_m;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        if (s == 32'd0) s = 32'd1;
        build_model(s);
        ready_m = 1'b0;
        go_m    = 1'b0;
        check_eq("gen_state", 32'(is_init), 32'd1);
        check_eq("rand_seeded", rand_val, s);
        check_eq("game_over_init", 32'(game_over), 32'd0);
        run_gen(inj);
    endtask

    task automatic check_board_sample(input int n_rand);
        check_cell(0, 0);
        check_cell(15, 0);
        check_cell(0, 15);
        check_cell(15, 15);
        for (int k = 0; k < n_rand; k++)
            check_cell(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    endtask

    task automatic random_ops(input int n);
        for (int k = 0; k < n; k++) begin
            int x, y;
            bit o, f;
            x = int'($urandom_range(0, 15));
            y = int'($urandom_range(0, 15));
            o = 1'($urandom_range(0, 1));
            f = 1'($urandom_range(0, 1));
            if (o && mine_m[x][y]) o = 1'b0;
            do_op(x, y, o, f);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ax, ay, bx, by, cx, cy, mx, my;
        bit ok;
        clear_model();
        ready_m = 1'b0;
        go_m    = 1'b0;

        // Asynchronous reset state
        glob_reset = 1'b1;
        #2;
        check_eq("rst_is_init", 32'(is_init), 32'd0);
        check_eq("rst_rand", rand_val, 32'h1);
        check_eq("rst_seed", seed, 32'd0);
        check_eq("rst_num_mines", 32'(num_mines), 32'd0);
        check_eq("rst_game_over", 32'(game_over), 32'd0);
        look(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        check_eq("rst_apparent", 32'(cell_val_apparent), 32'h10);
        glob_reset = 1'b0;
        @(posedge board_clk);
        #1;
        check_eq("seed_count", seed, seed_m);

        // Generation from seed 1
        start_init(-1);
        check_board_sample(6);

        // Open a non-mine cell twice
        find_cell(1'b0, ax, ay, ok);
        if (ok) begin
            do_op(ax, ay, 1'b1, 1'b0);
            check_eq("open_bit4", 32'(cell_val_apparent[4]), 32'd0);
            do_op(ax, ay, 1'b1, 1'b0);
        end
        // Flag, blocked open, unflag
        find_cell(1'b0, bx, by, ok);
        if (ok) begin
            do_op(bx, by, 1'b0, 1'b1);
            do_op(bx, by, 1'b1, 1'b0);
            do_op(bx, by, 1'b0, 1'b1);
        end
        // Open and flag together
        find_cell(1'b0, cx, cy, ok);
        if (ok) do_op(cx, cy, 1'b1, 1'b1);
        random_ops(40);

        // Open a mine
        find_cell(1'b1, mx, my, ok);
        if (ok) begin
            do_op(mx, my, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            go_m = 1'b1;
            check_eq("game_over_set", 32'(game_over), 32'd1);
            find_cell(1'b0, ax, ay, ok);
            if (ok) begin
                do_op(ax, ay, 1'b1, 1'b0);
                do_op(ax, ay, 1'b0, 1'b1);
            end
        end

        // Synchronous new-game clear
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        clear_model();
        ready_m = 1'b0;
        go_m    = 1'b0;
        check_eq("clr_game_over", 32'(game_over), 32'd0);
        check_eq("clr_is_init", 32'(is_init), 32'd0);
        check_eq("clr_num_mines", 32'(num_mines), 32'd0);
        check_board_sample(3);

        // reset beats init_pulse
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("reset_over_init", 32'(is_init), 32'd0);

        // Random seed, init pulse ignored during generation
        repeat ($urandom_range(0, 20)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        start_init(50);
        check_board_sample(8);
        random_ops(15);

        // Re-init from the ready state clears the board
        repeat ($urandom_range(1, 10)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        start_init(-1);
        check_board_sample(4);

        // glob_reset in the middle of generation
        repeat ($urandom_range(0, 10)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat ($urandom_range(5, 200)) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        glob_reset = 1'b1;
        #1;
        clear_model();
        ready_m = 1'b0;
        check_eq("mid_is_init", 32'(is_init), 32'd0);
        check_eq("mid_rand", rand_val, 32'h1);
        check_eq("mid_num_mines", 32'(num_mines), 32'd0);
        look(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        check_eq("mid_apparent", 32'(cell_val_apparent), 32'h10);
        glob_reset = 1'b0;
        @(posedge board_clk);
        #1;
        check_eq("post_rst_is_init", 32'(is_init), 32'd0);
        check_eq("post_rst_seed", seed, seed_m);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
